// File: rtl/wb_arbiter_n.sv
// Purpose : N-master Wishbone arbiter, round-robin grant with whole-cycle ownership (optional watchdog: WB_ARB_TIMEOUT_EN).
// Latency : grant registers 1 cycle after a request in IDLE; slave-side data/ack/err paths are combinational.
// Backpress: the owner keeps the bus until it drops cyc; other masters wait with no timeout or preemption.
module wb_arbiter_n #(
    parameter int N_MASTERS = 3,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int SEL_W     = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    // master side
    input  logic [N_MASTERS-1:0]        m_wb_cyc,
    input  logic [N_MASTERS-1:0]        m_wb_stb,
    input  logic [N_MASTERS-1:0]        m_wb_we,
    input  logic [N_MASTERS*ADDR_W-1:0] m_wb_adr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wb_o_dat,
    input  logic [N_MASTERS*SEL_W-1:0]  m_wb_sel,
    input  logic [N_MASTERS-1:0]        m_wb_4_burst,
    input  logic [N_MASTERS-1:0]        m_wb_8_burst,
    output logic [DATA_W-1:0]           m_wb_i_dat,
    output logic [N_MASTERS-1:0]        m_wb_ack,
    output logic [N_MASTERS-1:0]        m_wb_err,
    // slave side
    output logic                        s_wb_cyc,
    output logic                        s_wb_stb,
    output logic                        s_wb_we,
    output logic [ADDR_W-1:0]           s_wb_adr,
    output logic [DATA_W-1:0]           s_wb_o_dat,
    output logic [SEL_W-1:0]            s_wb_sel,
    output logic                        s_wb_4_burst,
    output logic                        s_wb_8_burst,
    input  logic [DATA_W-1:0]           s_wb_i_dat,
    input  logic                        s_wb_ack,
    input  logic                        s_wb_err,
    // status
    output logic [N_MASTERS-1:0]        o_grant,
    output logic                        o_busy
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] g_idx;     // index of current owner, valid in OWNED
    logic [IDX_W-1:0] last_idx;  // previous owner, round-robin search starts after it
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic             busy;
    logic             abort;     // watchdog has cut the slave off from the owner
    logic             to_hit;    // watchdog limit reached this cycle

    assign busy   = (state == OWNED);
    assign o_busy = busy;

    // Round-robin search: first requester upward from last_idx+1, wrapping.
    always_comb begin
        int k;
        k       = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            k = (int'(last_idx) + i) % N_MASTERS;
            if (!win_vld && m_wb_cyc[k]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
    end

    // Ownership FSM: grab in IDLE, hold while the owner's cyc stays high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_grant  <= '0;
            g_idx    <= '0;
            last_idx <= IDX_W'(N_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state   <= OWNED;
                        g_idx   <= win_idx;
                        o_grant <= {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
                    end
                end
                OWNED: begin
                    if (!m_wb_cyc[g_idx]) begin
                        state    <= IDLE;
                        last_idx <= g_idx;
                        o_grant  <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_grant <= '0;
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             stb_raw;

    // Owner's strobe before any abort masking; stalls are counted against it.
    assign stb_raw = busy & m_wb_stb[g_idx] & m_wb_cyc[g_idx];
    assign to_hit  = busy & (to_cnt == CNT_W'(TIMEOUT));

    // Watchdog: count unanswered strobe cycles, abort the owner when the limit is hit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt <= '0;
            abort  <= 1'b0;
        end else if (!busy) begin
            to_cnt <= '0;
            abort  <= 1'b0;
        end else if (to_hit) begin
            to_cnt <= '0;
            abort  <= 1'b1;
        end else if (stb_raw && !abort && !s_wb_ack && !s_wb_err) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    // Without the watchdog a silent slave holds the bus forever.
    assign abort  = 1'b0;
    assign to_hit = 1'b0;
`endif

    // Slave-side mux: mirror the owner in OWNED, all zero in IDLE.
    always_comb begin
        s_wb_cyc     = 1'b0;
        s_wb_stb     = 1'b0;
        s_wb_we      = 1'b0;
        s_wb_adr     = '0;
        s_wb_o_dat   = '0;
        s_wb_sel     = '0;
        s_wb_4_burst = 1'b0;
        s_wb_8_burst = 1'b0;
        if (busy) begin
            s_wb_cyc     = m_wb_cyc[g_idx] & ~abort;
            s_wb_stb     = m_wb_stb[g_idx] & m_wb_cyc[g_idx] & ~abort;
            s_wb_we      = m_wb_we[g_idx];
            s_wb_adr     = m_wb_adr[g_idx*ADDR_W +: ADDR_W];
            s_wb_o_dat   = m_wb_o_dat[g_idx*DATA_W +: DATA_W];
            s_wb_sel     = m_wb_sel[g_idx*SEL_W +: SEL_W];
            s_wb_4_burst = m_wb_4_burst[g_idx];
            s_wb_8_burst = m_wb_8_burst[g_idx];
        end
    end

    // Return path: ack/err reach only the granted master; read data is broadcast.
    assign m_wb_ack   = o_grant & {N_MASTERS{s_wb_ack}};
    assign m_wb_err   = o_grant & {N_MASTERS{s_wb_err | to_hit}};
    assign m_wb_i_dat = s_wb_i_dat;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n with three masters and a hand-driven slave.
// Inputs change 1 time unit after the rising edge; outputs are checked shortly after.
module tb_wb_arbiter_n;

    localparam int N = 3;
    localparam int A = 24;
    localparam int D = 16;
    localparam int S = 2;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic [N-1:0]   m_wb_cyc, m_wb_stb, m_wb_we, m_wb_4_burst, m_wb_8_burst;
    logic [N*A-1:0] m_wb_adr;
    logic [N*D-1:0] m_wb_o_dat;
    logic [N*S-1:0] m_wb_sel;
    logic [D-1:0]   m_wb_i_dat;
    logic [N-1:0]   m_wb_ack, m_wb_err;
    logic           s_wb_cyc, s_wb_stb, s_wb_we, s_wb_4_burst, s_wb_8_burst;
    logic [A-1:0]   s_wb_adr;
    logic [D-1:0]   s_wb_o_dat;
    logic [S-1:0]   s_wb_sel;
    logic [D-1:0]   s_wb_i_dat;
    logic           s_wb_ack, s_wb_err;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    int n_chk  = 0;
    int n_fail = 0;

    wb_arbiter_n #(
        .N_MASTERS(N), .ADDR_W(A), .DATA_W(D), .SEL_W(S), .TIMEOUT(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we),
        .m_wb_adr(m_wb_adr), .m_wb_o_dat(m_wb_o_dat), .m_wb_sel(m_wb_sel),
        .m_wb_4_burst(m_wb_4_burst), .m_wb_8_burst(m_wb_8_burst),
        .m_wb_i_dat(m_wb_i_dat), .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err),
        .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
        .s_wb_adr(s_wb_adr), .s_wb_o_dat(s_wb_o_dat), .s_wb_sel(s_wb_sel),
        .s_wb_4_burst(s_wb_4_burst), .s_wb_8_burst(s_wb_8_burst),
        .s_wb_i_dat(s_wb_i_dat), .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        i_rst_n      = 1'b0;
        m_wb_cyc     = '0; m_wb_stb = '0; m_wb_we = '0;
        m_wb_4_burst = '0; m_wb_8_burst = '0;
        m_wb_adr     = '0; m_wb_o_dat = '0; m_wb_sel = '0;
        s_wb_i_dat   = '0; s_wb_ack = 1'b0; s_wb_err = 1'b0;
        #12;
        chk("rst_grant", o_grant, 0);
        chk("rst_busy",  o_busy, 0);
        chk("rst_scyc",  s_wb_cyc, 0);
        chk("rst_ack",   m_wb_ack, 0);
        chk("rst_err",   m_wb_err, 0);
        tick(); i_rst_n = 1'b1;
        tick();

        // Round-robin: all three request, each does one beat, grants 0,1,2,0.
        m_wb_cyc = 3'b111; m_wb_stb = 3'b111;
        for (int i = 0; i < 4; i++) begin
            int exp_g;
            exp_g = i % 3;
            tick();
            s_wb_ack = 1'b1; #1;
            chk("rr_grant", o_grant, 1 << exp_g);
            chk("rr_ack",   m_wb_ack, 1 << exp_g);
            tick();
            s_wb_ack = 1'b0; m_wb_cyc[exp_g] = 1'b0; m_wb_stb[exp_g] = 1'b0; #1;
            chk("rr_release_scyc", s_wb_cyc, 0);
            tick();
            chk("rr_bubble_grant", o_grant, 0);
            chk("rr_bubble_scyc",  s_wb_cyc, 0);
            m_wb_cyc = 3'b111; m_wb_stb = 3'b111;
        end
        m_wb_cyc = '0; m_wb_stb = '0;
        tick();

        // Single read by master 1.
        m_wb_cyc = 3'b010; m_wb_stb = 3'b010;
        m_wb_adr = {24'h000000, 24'h000123, 24'h000000}; #1;
        chk("rd_pre_grant", o_grant, 0);
        tick(); #1;
        chk("rd_grant", o_grant, 3'b010);
        chk("rd_busy",  o_busy, 1);
        chk("rd_scyc",  s_wb_cyc, 1);
        chk("rd_sstb",  s_wb_stb, 1);
        chk("rd_adr",   s_wb_adr, 24'h000123);
        tick(); tick();
        s_wb_ack = 1'b1; s_wb_i_dat = 16'hBEEF; #1;
        chk("rd_ack", m_wb_ack, 3'b010);
        chk("rd_dat", m_wb_i_dat, 16'hBEEF);
        tick();
        s_wb_ack = 1'b0; m_wb_cyc = '0; m_wb_stb = '0; #1;
        chk("rd_drop_scyc",  s_wb_cyc, 0);
        chk("rd_drop_grant", o_grant, 3'b010);
        tick(); #1;
        chk("rd_idle_grant", o_grant, 0);
        chk("rd_idle_busy",  o_busy, 0);
        chk("rd_idle_adr",   s_wb_adr, 0);

        // Burst hold: master 2 does 8 beats while master 0 waits.
        m_wb_cyc = 3'b101; m_wb_stb = 3'b101; m_wb_8_burst = 3'b100;
        tick(); #1;
        chk("bu_grant",  o_grant, 3'b100);
        chk("bu_8burst", s_wb_8_burst, 1);
        for (int b = 0; b < 8; b++) begin
            s_wb_ack = 1'b1; #1;
            chk("bu_ack",   m_wb_ack, 3'b100);
            chk("bu_grant", o_grant, 3'b100);
            tick();
        end
        s_wb_ack = 1'b0; m_wb_cyc[2] = 1'b0; m_wb_stb[2] = 1'b0; m_wb_8_burst = '0; #1;
        chk("bu_drop_scyc",  s_wb_cyc, 0);
        chk("bu_drop_grant", o_grant, 3'b100);
        tick(); #1;
        chk("bu_bubble", o_grant, 0);
        tick(); #1;
        chk("bu_next_grant", o_grant, 3'b001);

        // Error on master 0's write.
        m_wb_we = 3'b001; m_wb_o_dat = {16'h0000, 16'h0000, 16'h1234};
        s_wb_err = 1'b1; #1;
        chk("er_err",  m_wb_err, 3'b001);
        chk("er_we",   s_wb_we, 1);
        chk("er_dat",  s_wb_o_dat, 16'h1234);
        tick();
        s_wb_err = 1'b0; #1;
        chk("er_err_clr", m_wb_err, 0);
        chk("er_grant",   o_grant, 3'b001);
        tick(); #1;
        chk("er_grant_held", o_grant, 3'b001);
        m_wb_cyc = '0; m_wb_stb = '0; m_wb_we = '0;
        tick(); #1;
        chk("er_release", o_grant, 0);

        // Reset during beat 3 of a 4-beat burst by master 1.
        m_wb_cyc = 3'b010; m_wb_stb = 3'b010; m_wb_4_burst = 3'b010;
        m_wb_adr = {24'h000000, 24'h000200, 24'h000000};
        tick(); #1;
        chk("rb_grant",  o_grant, 3'b010);
        chk("rb_4burst", s_wb_4_burst, 1);
        for (int b = 0; b < 2; b++) begin
            s_wb_ack = 1'b1;
            tick();
        end
        s_wb_ack = 1'b1; #2;
        i_rst_n = 1'b0; #1;
        chk("rb_grant0", o_grant, 0);
        chk("rb_busy0",  o_busy, 0);
        chk("rb_scyc0",  s_wb_cyc, 0);
        chk("rb_sstb0",  s_wb_stb, 0);
        chk("rb_burst0", s_wb_4_burst, 0);
        chk("rb_adr0",   s_wb_adr, 0);
        chk("rb_ack0",   m_wb_ack, 0);
        s_wb_ack = 1'b0; m_wb_4_burst = '0;
        m_wb_cyc = 3'b011; m_wb_stb = 3'b011;
        tick(); i_rst_n = 1'b1;
        tick(); #1;
        chk("rb_first_winner", o_grant, 3'b001);
        m_wb_cyc = '0; m_wb_stb = '0;
        tick(); tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: master 2 strobes, slave stays silent.
        m_wb_cyc = 3'b100; m_wb_stb = 3'b100;
        tick(); #1;
        chk("to_grant", o_grant, 3'b100);
        chk("to_err_start", m_wb_err, 0);
        for (int k = 1; k < 16; k++) begin
            tick(); #1;
            chk("to_err_early", m_wb_err, 0);
        end
        tick(); #1;
        chk("to_err_pulse", m_wb_err, 3'b100);
        tick(); #1;
        chk("to_err_once",  m_wb_err, 0);
        chk("to_scyc_cut",  s_wb_cyc, 0);
        chk("to_sstb_cut",  s_wb_stb, 0);
        chk("to_grant_hold", o_grant, 3'b100);
        m_wb_cyc = '0; m_wb_stb = '0;
        tick(); tick(); #1;
        chk("to_release", o_grant, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_n.md
# wb_arbiter_n

Parametrised N-master Wishbone arbiter that merges the per-cache Wishbone masters (instruction caches, data cache, future extra cores) onto the single inner bus toward the outer interconnect. It generalises the fixed three-master arbitration inside the inner interconnect to any master count, with the following behaviour:
- fair round-robin grant;
- whole-cycle ownership, so 4- and 8-beat bursts are never split;
- a per-master error return path;
- an optional bus-hang watchdog.

## Interface
Parameters:
- N_MASTERS, 3, number of requesting masters (≥2)
- ADDR_W, 24, Wishbone address width
- DATA_W, 16, Wishbone data width
- SEL_W, 2, byte-select width
- TIMEOUT, 255, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN)

Ports:
- i_clk  in  1  single clock, all logic rising-edge
- i_rst_n  in  1  asynchronous active-low reset
- m_wb_cyc  in  N_MASTERS  per-master cycle request
- m_wb_stb  in  N_MASTERS  per-master strobe
- m_wb_we  in  N_MASTERS  per-master write enable
- m_wb_adr  in  N_MASTERS*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
- m_wb_o_dat  in  N_MASTERS*DATA_W  packed write data from masters
- m_wb_sel  in  N_MASTERS*SEL_W  packed byte selects
- m_wb_4_burst, m_wb_8_burst  in  N_MASTERS each  burst hints
- m_wb_i_dat  out  DATA_W  read data, broadcast to all masters
- m_wb_ack, m_wb_err  out  N_MASTERS each  routed to the granted master only
- s_wb_cyc, s_wb_stb, s_wb_we  out  1 each  slave-side controls
- s_wb_adr  out  ADDR_W; s_wb_o_dat out DATA_W; s_wb_sel out SEL_W; s_wb_4_burst, s_wb_8_burst out 1 each
- s_wb_i_dat  in  DATA_W; s_wb_ack, s_wb_err  in  1 each
- o_grant  out  N_MASTERS  registered one-hot grant; all zero when idle
- o_busy  out  1  high in OWNED state

## Operation
- FSM states: IDLE, OWNED.
- IDLE behaviour:
  - If any m_wb_cyc is high, pick the first requester searching upward (with wrap) from index last+1.
  - Register the winner in o_grant and go to OWNED.
  - All s_wb_* outputs are 0 while in IDLE.
- OWNED behaviour:
  - The s_wb_* outputs are driven combinationally from the granted master.
  - s_wb_cyc = m_wb_cyc[g]; s_wb_stb = m_wb_stb[g] & m_wb_cyc[g].
  - m_wb_ack[g] = s_wb_ack and m_wb_err[g] = s_wb_err; every other master sees 0 on both.
  - m_wb_i_dat = s_wb_i_dat at all times.
- Release:
  - When m_wb_cyc[g] is low in OWNED, go to IDLE and set last = g.
  - s_wb_cyc drops in that same cycle, because it follows the master's cyc.
- Ownership is held across any number of stb/ack beats, including burst hints. A master holding cyc is never preempted.
- The last pointer resets to N_MASTERS-1, so master 0 wins first after reset.
- Reset asserted mid-transfer clears everything immediately:
  - o_grant = 0, o_busy = 0, all s_wb_* = 0, all m_wb_ack/err = 0;
  - state = IDLE;
  - the slave transfer is abandoned.

## Timing
- Grant latency: a request in IDLE at edge t drives s_wb_cyc from cycle t+1.
- Handover: at least one IDLE cycle separates two owners, so back-to-back different masters see a 1-cycle bubble.
- Ack/err path from slave to master is combinational (zero latency). Data path is combinational.
- Simultaneous release by g and request by g: g loses priority to any other pending requester.
- Reset values: every output is 0.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A counter of $clog2(TIMEOUT+1) bits increments each OWNED cycle in which s_wb_stb is high and neither s_wb_ack nor s_wb_err is asserted.
  - It clears on ack, err, stb low, or leaving OWNED.
  - When it reaches TIMEOUT, m_wb_err[g] pulses for 1 cycle and an abort flag is set.
  - While abort is set, s_wb_cyc and s_wb_stb are forced to 0 until m_wb_cyc[g] drops. Abort then clears on the return to IDLE.
- WB_ARB_TIMEOUT_EN undefined: no counter and no abort logic exist; a slave that never acks hangs the bus indefinitely.

## Test plan
- Single read: master 1 raises cyc/stb with adr=0x000123, slave acks with dat=0xBEEF 2 cycles later.
  - Required: o_grant=3'b010 one cycle after the request.
  - Required: m_wb_ack[1] pulses with m_wb_i_dat=0xBEEF; m_wb_ack[0] and m_wb_ack[2] stay 0.
- Round-robin: all three masters request continuously, each doing a single-beat transfer.
  - Required: grants go 0,1,2,0, with one IDLE cycle between each.
- Burst hold: master 2 sets 8_burst and performs 8 stb/ack beats while master 0 also requests.
  - Required: master 2 keeps the grant for all 8 acks.
  - Required: master 0 is granted only after master 2 drops cyc.
- Error: slave returns err on master 0's write.
  - Required: m_wb_err[0]=1 for that cycle; the other err lines stay 0.
  - Required: grant is unchanged until master 0 drops cyc.
- Timeout (with WB_ARB_TIMEOUT_EN, TIMEOUT=16): slave never acks.
  - Required: m_wb_err[g] pulses exactly 16 stalled cycles after stb rises.
  - Required: s_wb_cyc=0 afterwards until the master releases.
- Reset mid-burst: deassert i_rst_n during beat 3 of a 4-beat burst.
  - Required: all outputs are 0 immediately, asynchronously.
  - Required: after reset release, master 0 wins a simultaneous 0/1 request.
